// File: rtl/fetch_seq_pkg.sv
// Shared encodings for the EV22 program-flow controller: decoder commands and
// sequencer states.
package fetch_seq_pkg;

   typedef enum logic [2:0] {
      CMD_SEQ  = 3'd0,
      CMD_JMP  = 3'd1,
      CMD_BSR  = 3'd2,
      CMD_RET  = 3'd3,
      CMD_RETI = 3'd4,
      CMD_HALT = 3'd5
   } cmd_e;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/ret_stack.sv
// Subroutine/interrupt return stack. Within one cycle the operations apply in
// this order: pop, push (din), push2 (din2). The caller never exceeds the depth.
module ret_stack #(
   parameter int PC_W        = 11,
   parameter int STACK_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               nreset,
   input  logic                               push,
   input  logic                               pop,
   input  logic [PC_W-1:0]                    din,
   input  logic                               push2,
   input  logic [PC_W-1:0]                    din2,
   output logic [PC_W-1:0]                    dout,
   output logic                               full,
   output logic                               empty,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

   localparam int SP_W = $clog2(STACK_DEPTH+1);

   logic [STACK_DEPTH-1:0][PC_W-1:0] mem_q;
   logic [SP_W-1:0]                  sp_q;
   logic [SP_W-1:0]                  wa;
   logic [SP_W-1:0]                  wa2;

   // A pop frees its slot before the same-cycle push reuses it.
   assign wa  = sp_q - SP_W'(pop);
   assign wa2 = wa + SP_W'(push);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sp_q  <= '0;
         mem_q <= '0;
      end else begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && (wa == SP_W'(i)))
               mem_q[i] <= din;
            if (push2 && (wa2 == SP_W'(i)))
               mem_q[i] <= din2;
         end
         sp_q <= wa2 + SP_W'(push2);
      end
   end

   always_comb begin
      dout = '0;
      for (int i = 0; i < STACK_DEPTH; i++)
         if (sp_q == SP_W'(i + 1))
            dout = mem_q[i];
   end

   assign full  = (sp_q == SP_W'(STACK_DEPTH));
   assign empty = (sp_q == '0);
   assign sp    = sp_q;

endmodule

// File: rtl/fetch_sequencer.sv
// EV22 program-flow controller: PC, ROM fetch handshake, decoder command
// resolution and interrupt entry between instructions.
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int              PC_W        = 11,
   parameter int              STACK_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_VEC   = '0,
   parameter logic [PC_W-1:0] IRQ_VEC     = 11'h7F8
) (
   input  logic             clk,
   input  logic             nreset,
   output logic [PC_W-1:0]  rom_addr,
   output logic             rom_req,
   input  logic             rom_ack,
   output logic             instr_valid,
   input  logic             cmd_valid,
   input  logic [2:0]       cmd,
   input  logic             cond,
   input  logic [PC_W-1:0]  target,
   input  logic             irq,
   output logic             irq_ack,
   output logic [PC_W-1:0]  pc,
   output logic             halted,
   output logic             stack_ovf,
   output logic             stack_unf
);

   localparam int SP_W = $clog2(STACK_DEPTH+1);

   state_t          state_q, state_n;
   logic [PC_W-1:0] pc_q, pc_n, pc_inc, npc;
   logic            ie_q, ie_n;
   logic            rom_req_q, irq_ack_q, ovf_q, unf_q;
   logic            set_ovf, set_unf, take_irq;

   logic            st_push, st_pop, st_push2, st_full, st_empty;
   logic [PC_W-1:0] st_din, st_din2, st_dout;
   logic [SP_W-1:0] st_sp, sp_post;

   ret_stack #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
      .clk    (clk),
      .nreset (nreset),
      .push   (st_push),
      .pop    (st_pop),
      .din    (st_din),
      .push2  (st_push2),
      .din2   (st_din2),
      .dout   (st_dout),
      .full   (st_full),
      .empty  (st_empty),
      .sp     (st_sp)
   );

   assign pc_inc = pc_q + PC_W'(1);

   always_comb begin
      state_n  = state_q;
      pc_n     = pc_q;
      ie_n     = ie_q;
      npc      = pc_inc;
      st_push  = 1'b0;
      st_pop   = 1'b0;
      st_push2 = 1'b0;
      st_din   = pc_inc;
      st_din2  = '0;
      set_ovf  = 1'b0;
      set_unf  = 1'b0;
      take_irq = 1'b0;
      sp_post  = st_sp;
      case (state_q)
         BOOT:  state_n = FETCH;
         FETCH: if (rom_ack) state_n = EXEC;
         EXEC: begin
            if (cmd_valid) begin
               state_n = FETCH;
               case (cmd)
                  CMD_JMP: if (cond) npc = target;
                  CMD_BSR: begin
                     if (cond) begin
                        if (!st_full) begin
                           st_push = 1'b1;
                           npc     = pc_q + target;
                        end else begin
                           set_ovf = 1'b1;
                        end
                     end
                  end
                  CMD_RET, CMD_RETI: begin
                     if (!st_empty) begin
                        st_pop = 1'b1;
                        npc    = st_dout;
                     end else begin
                        set_unf = 1'b1;
                     end
                     if (cmd == CMD_RETI) ie_n = 1'b1;
                  end
                  CMD_HALT: state_n = HALT;
                  default: ;
               endcase
               if (cmd != CMD_HALT) begin
                  // Interrupt is taken only if the return address still fits
                  // after this instruction's own stack effect.
                  sp_post = st_sp - SP_W'(st_pop) + SP_W'(st_push);
                  if (irq && ie_n && (sp_post < SP_W'(STACK_DEPTH))) begin
                     take_irq = 1'b1;
                     ie_n     = 1'b0;
                     pc_n     = IRQ_VEC;
                     if (st_push) begin
                        st_push2 = 1'b1;
                        st_din2  = npc;
                     end else begin
                        st_push  = 1'b1;
                        st_din   = npc;
                     end
                  end else begin
                     pc_n = npc;
                  end
               end
            end
         end
         HALT: begin
            if (irq && ie_q && !st_full) begin
               take_irq = 1'b1;
               st_push  = 1'b1;
               st_din   = pc_inc;
               ie_n     = 1'b0;
               pc_n     = IRQ_VEC;
               state_n  = FETCH;
            end
         end
         default: state_n = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= BOOT;
         pc_q      <= RESET_VEC;
         ie_q      <= 1'b1;
         rom_req_q <= 1'b0;
         irq_ack_q <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_n;
         pc_q      <= pc_n;
         ie_q      <= ie_n;
         rom_req_q <= (state_n == FETCH);
         irq_ack_q <= take_irq;
         ovf_q     <= ovf_q | set_ovf;
         unf_q     <= unf_q | set_unf;
      end
   end

   assign rom_addr    = pc_q;
   assign pc          = pc_q;
   assign rom_req     = rom_req_q;
   assign irq_ack     = irq_ack_q;
   assign stack_ovf   = ovf_q;
   assign stack_unf   = unf_q;
   assign instr_valid = (state_q == EXEC);
   assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a command table walked from reset, plus
// hand sequences for fetch stalls, HALT wake-up and mid-fetch reset.
module tb_fetch_sequencer;

   localparam logic [10:0] IV = 11'h7F8;

   logic        clk = 1'b0;
   logic        nreset = 1'b1;
   logic [10:0] rom_addr;
   logic        rom_req;
   logic        rom_ack = 1'b1;
   logic        instr_valid;
   logic        cmd_valid = 1'b0;
   logic [2:0]  cmd = 3'd0;
   logic        cond = 1'b0;
   logic [10:0] target = '0;
   logic        irq = 1'b0;
   logic        irq_ack;
   logic [10:0] pc;
   logic        halted;
   logic        stack_ovf;
   logic        stack_unf;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_sequencer dut (
      .clk         (clk),
      .nreset      (nreset),
      .rom_addr    (rom_addr),
      .rom_req     (rom_req),
      .rom_ack     (rom_ack),
      .instr_valid (instr_valid),
      .cmd_valid   (cmd_valid),
      .cmd         (cmd),
      .cond        (cond),
      .target      (target),
      .irq         (irq),
      .irq_ack     (irq_ack),
      .pc          (pc),
      .halted      (halted),
      .stack_ovf   (stack_ovf),
      .stack_unf   (stack_unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  cmd;
      logic        cond;
      logic [10:0] tgt;
      logic        irq;
      logic [10:0] pc;
      logic        ack;
      logic [2:0]  flg;   // {halted, stack_unf, stack_ovf}
   } vec_t;

   vec_t tv[33];

   function automatic vec_t mk(input logic [2:0] c, input logic cd, input logic [10:0] t,
                               input logic i, input logic [10:0] p, input logic a,
                               input logic [2:0] f);
      vec_t v;
      v.cmd = c; v.cond = cd; v.tgt = t; v.irq = i; v.pc = p; v.ack = a; v.flg = f;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for EXEC, resolves one instruction, returns 1 ns after the edge.
   task automatic exec_instr(input logic [2:0] c, input logic cd, input logic [10:0] t,
                             input logic i);
      int n = 0;
      while (!instr_valid && n < 20) begin
         step();
         n++;
      end
      chk("exec_wait", {31'd0, instr_valid}, 32'd1);
      cmd_valid = 1'b1; cmd = c; cond = cd; target = t; irq = i;
      step();
      cmd_valid = 1'b0; irq = 1'b0; cond = 1'b0;
   endtask

   initial begin
      tv[0]  = mk(3'd0, 0, 11'd0,    0, 11'd5,   0, 3'b000);
      tv[1]  = mk(3'd1, 0, 11'd99,   0, 11'd6,   0, 3'b000);
      tv[2]  = mk(3'd1, 1, 11'd10,   0, 11'd10,  0, 3'b000);
      tv[3]  = mk(3'd2, 1, 11'd20,   0, 11'd30,  0, 3'b000);
      tv[4]  = mk(3'd3, 0, 11'd0,    0, 11'd11,  0, 3'b000);
      tv[5]  = mk(3'd2, 0, 11'd5,    0, 11'd12,  0, 3'b000);
      tv[6]  = mk(3'd7, 1, 11'd9,    0, 11'd13,  0, 3'b000);
      tv[7]  = mk(3'd2, 1, 11'd2,    0, 11'd15,  0, 3'b000);
      tv[8]  = mk(3'd2, 1, 11'd2,    0, 11'd17,  0, 3'b000);
      tv[9]  = mk(3'd2, 1, 11'd2,    0, 11'd19,  0, 3'b000);
      tv[10] = mk(3'd2, 1, 11'd2,    0, 11'd21,  0, 3'b000);
      tv[11] = mk(3'd2, 1, 11'd2,    0, 11'd22,  0, 3'b001);
      tv[12] = mk(3'd3, 0, 11'd0,    0, 11'd20,  0, 3'b001);
      tv[13] = mk(3'd3, 0, 11'd0,    0, 11'd18,  0, 3'b001);
      tv[14] = mk(3'd3, 0, 11'd0,    0, 11'd16,  0, 3'b001);
      tv[15] = mk(3'd3, 0, 11'd0,    0, 11'd14,  0, 3'b001);
      tv[16] = mk(3'd3, 0, 11'd0,    0, 11'd15,  0, 3'b011);
      tv[17] = mk(3'd0, 0, 11'd0,    0, 11'd16,  0, 3'b011);
      tv[18] = mk(3'd1, 1, 11'd40,   0, 11'd40,  0, 3'b011);
      tv[19] = mk(3'd1, 1, 11'd100,  1, IV,      1, 3'b011);
      tv[20] = mk(3'd0, 0, 11'd0,    1, IV + 11'd1, 0, 3'b011);
      tv[21] = mk(3'd4, 0, 11'd0,    0, 11'd100, 0, 3'b011);
      tv[22] = mk(3'd0, 0, 11'd0,    1, IV,      1, 3'b011);
      tv[23] = mk(3'd4, 0, 11'd0,    0, 11'd101, 0, 3'b011);
      tv[24] = mk(3'd1, 1, 11'h7FF,  0, 11'h7FF, 0, 3'b011);
      tv[25] = mk(3'd0, 0, 11'd0,    0, 11'd0,   0, 3'b011);
      tv[26] = mk(3'd2, 1, 11'h7FE,  0, 11'h7FE, 0, 3'b011);
      tv[27] = mk(3'd3, 0, 11'd0,    0, 11'd1,   0, 3'b011);
      tv[28] = mk(3'd2, 1, 11'd10,   1, IV,      1, 3'b011);
      tv[29] = mk(3'd4, 0, 11'd0,    0, 11'd11,  0, 3'b011);
      tv[30] = mk(3'd3, 0, 11'd0,    0, 11'd2,   0, 3'b011);
      tv[31] = mk(3'd1, 1, 11'd50,   0, 11'd50,  0, 3'b011);
      tv[32] = mk(3'd5, 0, 11'd0,    0, 11'd50,  0, 3'b111);

      // Reset state
      #1 nreset = 1'b0;
      #10;
      chk("rst_pc", {21'd0, pc}, 32'd0);
      chk("rst_req", {31'd0, rom_req}, 32'd0);
      chk("rst_iv", {31'd0, instr_valid}, 32'd0);
      chk("rst_flags", {28'd0, irq_ack, halted, stack_unf, stack_ovf}, 32'd0);

      // Back-to-back SEQ with immediate ack: two cycles per instruction
      cmd_valid = 1'b1; cmd = 3'd0;
      @(negedge clk);
      nreset = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k % 2 == 1) begin
            chk("seq_req", {31'd0, rom_req}, 32'd1);
            chk("seq_addr", {21'd0, rom_addr}, 32'((k - 1) / 2));
            chk("seq_iv", {31'd0, instr_valid}, 32'd0);
         end else begin
            chk("seq_req", {31'd0, rom_req}, 32'd0);
            chk("seq_pc", {21'd0, pc}, 32'((k - 2) / 2));
            chk("seq_iv", {31'd0, instr_valid}, 32'd1);
         end
      end
      cmd_valid = 1'b0;

      // Command table
      for (int i = 0; i < 33; i++) begin
         exec_instr(tv[i].cmd, tv[i].cond, tv[i].tgt, tv[i].irq);
         chk($sformatf("tv%0d_pc", i), {21'd0, pc}, {21'd0, tv[i].pc});
         chk($sformatf("tv%0d_addr", i), {21'd0, rom_addr}, {21'd0, tv[i].pc});
         chk($sformatf("tv%0d_ack", i), {31'd0, irq_ack}, {31'd0, tv[i].ack});
         chk($sformatf("tv%0d_flg", i), {29'd0, halted, stack_unf, stack_ovf},
             {29'd0, tv[i].flg});
      end

      // HALT: no fetch; irq wakes it with return address pc+1
      step(); step();
      chk("halt_req", {31'd0, rom_req}, 32'd0);
      chk("halt_hold", {30'd0, halted, instr_valid}, 32'b10);
      irq = 1'b1;
      step();
      irq = 1'b0;
      chk("wake_pc", {21'd0, pc}, {21'd0, IV});
      chk("wake_ack", {31'd0, irq_ack}, 32'd1);
      chk("wake_halted", {31'd0, halted}, 32'd0);
      chk("wake_req", {31'd0, rom_req}, 32'd1);
      step();
      chk("ack_pulse", {31'd0, irq_ack}, 32'd0);
      exec_instr(3'd4, 0, 11'd0, 0);
      chk("reti_51", {21'd0, pc}, 32'd51);

      // Fetch stall at pc=5: request and address held until ack
      exec_instr(3'd1, 1, 11'd5, 0);
      rom_ack = 1'b0;
      chk("stall_req0", {31'd0, rom_req}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_req", {31'd0, rom_req}, 32'd1);
         chk("stall_addr", {21'd0, rom_addr}, 32'd5);
         chk("stall_iv", {31'd0, instr_valid}, 32'd0);
      end
      rom_ack = 1'b1;
      step();
      chk("stall_iv_after", {31'd0, instr_valid}, 32'd1);
      chk("stall_req_after", {31'd0, rom_req}, 32'd0);
      step();
      chk("exec_ignores_ack", {31'd0, instr_valid}, 32'd1);
      chk("exec_pc_hold", {21'd0, pc}, 32'd5);

      // Reset in the middle of a fetch
      exec_instr(3'd0, 0, 11'd0, 0);
      rom_ack = 1'b0;
      chk("pre_rst_pc", {21'd0, pc}, 32'd6);
      @(negedge clk);
      nreset = 1'b0;
      #1;
      chk("mid_rst_pc", {21'd0, pc}, 32'd0);
      chk("mid_rst_req", {31'd0, rom_req}, 32'd0);
      chk("mid_rst_flags", {30'd0, stack_unf, stack_ovf}, 32'd0);
      @(negedge clk);
      nreset = 1'b1;
      rom_ack = 1'b1;
      step();
      chk("reboot_req", {31'd0, rom_req}, 32'd1);
      chk("reboot_addr", {21'd0, rom_addr}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-flow controller for the EV22 core.
- Owns the PC, the subroutine/interrupt return stack and the ROM fetch handshake.
- Sequences each instruction through fetch → execute-resolve, applies jump/call/return/halt commands from the decoder, and injects interrupt entry between instructions.
- Replaces ad-hoc PC update logic with an explicit FSM and defined stack overflow/underflow behaviour.

Parameters:
- PC_W, 11, PC and ROM address width.
- STACK_DEPTH, 4, number of return-stack entries.
- RESET_VEC, 0, PC loaded at reset.
- IRQ_VEC, 11'h7F8, interrupt entry address.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous, active-low reset
- rom_addr  out  PC_W  fetch address (equals pc)
- rom_req  out  1  fetch request
- rom_ack  in  1  ROM data valid this cycle
- instr_valid  out  1  fetched instruction presented to decoder
- cmd_valid  in  1  decoder has resolved the current instruction
- cmd  in  3  0 SEQ, 1 JMP, 2 BSR, 3 RET, 4 RETI, 5 HALT, 6/7 treated as SEQ
- cond  in  1  branch/call condition (B1 output)
- target  in  PC_W  JMP absolute address / BSR signed offset
- irq  in  1  level interrupt request
- irq_ack  out  1  one-cycle pulse on interrupt entry
- pc  out  PC_W  current PC
- halted  out  1  high in HALT state
- stack_ovf  out  1  sticky overflow flag
- stack_unf  out  1  sticky underflow flag

Behaviour:
- Reset (async, nreset=0): state BOOT, pc=RESET_VEC, sp=0, ie=1; rom_req, instr_valid, irq_ack, halted, stack_ovf, stack_unf all 0. Reset mid-fetch abandons the request, with no ROM-side obligation.
- BOOT: one cycle, then FETCH.
- FETCH:
  - rom_req=1, rom_addr=pc; hold until rom_ack=1.
  - In the ack cycle, go to EXEC. rom_ack outside FETCH is ignored.
- EXEC:
  - instr_valid=1; wait for cmd_valid.
  - On cmd_valid, compute npc by cmd:
    - SEQ: npc=pc+1.
    - JMP: cond ? target : pc+1.
    - BSR, cond=1, sp<STACK_DEPTH: push pc+1; npc=pc+target (mod 2^PC_W).
    - BSR, cond=1, stack full: set stack_ovf; npc=pc+1; no push.
    - BSR, cond=0: npc=pc+1.
    - RET: sp>0 → pop into npc; sp=0 → set stack_unf, npc=pc+1.
    - RETI: as RET, plus ie=1.
    - HALT: go to HALT, pc unchanged.
  - Interrupt check, same edge, all non-HALT cmds: if irq && ie && post-command sp<STACK_DEPTH, then push npc, pc=IRQ_VEC, ie=0, irq_ack=1 for that cycle. Otherwise pc=npc.
  - Next state FETCH.
  - BSR+irq in the same cycle gives two pushes, BSR first. If the BSR fills the stack, the irq is deferred; it stays pending as a level.
- HALT:
  - halted=1; rom_req=0.
  - On irq && ie with space: push pc+1, enter IRQ_VEC, irq_ack pulse, go to FETCH.
  - Otherwise remain in HALT. Only reset exits with ie=0.
- Throughput: minimum 2 cycles per instruction (ack in first FETCH cycle, cmd_valid in first EXEC cycle).
- Stack: sp ranges 0..STACK_DEPTH. Push writes stack[sp] then sp+1; pop reads stack[sp-1].
- Flags: stack_ovf and stack_unf are sticky and cleared only by reset.
- PC arithmetic wraps modulo 2^PC_W; pc+1 at max gives 0.
- All outputs are registered except rom_addr=pc and instr_valid/halted, which are decoded from state.

Decomposition:
- Package fetch_seq_pkg holds:
  - cmd encodings: CMD_SEQ, CMD_JMP, CMD_BSR, CMD_RET, CMD_RETI, CMD_HALT.
  - state encoding: BOOT, FETCH, EXEC, HALT.
- Sub-module ret_stack (PC_W, STACK_DEPTH):
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty, sp.
  - Supports two pushes per cycle via push2/din2 for the BSR+irq case.
- The FSM and npc mux stay in fetch_sequencer.

Test Plan:
- Reset release, rom_ack tied 1, cmd=SEQ every EXEC → rom_addr 0,1,2,3 on successive FETCH cycles; 2 cycles per instruction.
- rom_ack delayed 3 cycles at pc=5 → rom_req held 4 cycles, rom_addr stable at 5, instr_valid only after ack.
- pc=10, BSR cond=1 target=20 → pc=30; then RET → pc=11, sp back to 0.
- Five nested BSR (depth 4) → 5th sets stack_ovf, pc=pc+1. RET with sp=0 → stack_unf=1, pc+1. Both flags stay set until reset.
- irq=1 during EXEC of JMP cond=1 target=100 at pc=40 → irq_ack pulse, pc=IRQ_VEC, pushed 100. RETI → pc=100, ie=1. Second irq before RETI is ignored.
- HALT at pc=50 → halted=1, rom_req=0. irq → pushed 51, pc=IRQ_VEC. Assert nreset during FETCH → immediate pc=0, rom_req=0.
